// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage: state encoding, MEM/WB widths
// and the MEM/WB control field layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  localparam int MEMWB_DATA_W = 96;
  localparam int MEMWB_CTRL_W = 8;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic [1:0] result_src;
  } memwb_ctrl_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module pipe_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_stage_elastic.sv
// Elastic pipeline register with valid/ready, flush and bubble zeroing of control.
// Define PIPE_SKID_EN for the 2-entry skid variant with a registered in_ready.
//
// Handshake: an entry moves when valid & ready are both high at a rising edge;
// a producer holds valid and its payload stable until that edge.
module pipeline_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = MEMWB_DATA_W,
  parameter int CTRL_W = MEMWB_CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        dbg_state
);

  pipe_state_t       r_state;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic              w_accept;
  logic              w_consume;

  assign out_valid = (r_state != EMPTY);
  assign w_consume = out_valid & out_ready;
  assign w_accept  = in_valid & in_ready;

`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic              r_in_ready;

  // Ready comes from a flop, so out_ready never reaches in_ready combinationally.
  assign in_ready = r_in_ready & reset_n;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
      r_in_ready  <= 1'b1;
    end else if (flush) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
            r_state     <= FULL;
          end
        end
        FULL: begin
          if (w_accept && w_consume) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (w_accept) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
            r_state     <= SKID;
            r_in_ready  <= 1'b0;
          end else if (w_consume) begin
            r_state <= EMPTY;
          end
        end
        SKID: begin
          if (w_consume) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
            r_state     <= FULL;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state    <= EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end
`else
  assign in_ready = reset_n & (~out_valid | out_ready);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
            r_state     <= FULL;
          end
        end
        FULL: begin
          if (w_accept) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (w_consume) begin
            r_state <= EMPTY;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end
`endif

  // Bubbles carry zero control so no write strobe leaks past an empty slot.
  assign out_data  = r_main_data;
  assign out_ctrl  = out_valid ? r_main_ctrl : '0;
  assign dbg_state = r_state;

  pipe_sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clock  (clock),
    .i_clear(~reset_n),
    .i_inc  (out_valid & ~out_ready),
    .o_count(stall_cnt)
  );

endmodule
